// File: rtl/cmul_share_arbiter.sv
// Shared complex multiplier behind a round-robin arbiter.
// Stage 1 holds the granted operands and tag, and stage 2 holds the product and tag.
// A result appears two edges after its request is accepted.
// The pipeline sustains one operation per cycle under a valid/ready result port.

// Wrapped complex multiply: each component is taken mod 2^W and then shifted right by 1.
module mul_complex #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH:0] a_re,
  input  logic [DATA_WIDTH:0] a_im,
  input  logic [DATA_WIDTH:0] b_re,
  input  logic [DATA_WIDTH:0] b_im,
  output logic [DATA_WIDTH:0] re,
  output logic [DATA_WIDTH:0] im
);
  localparam int W = DATA_WIDTH + 1;

  logic [W-1:0] p_rr, p_ii, p_ri, p_ir, s_re, s_im;

  // The low W bits of each product are all that survive the modulo.
  always_comb begin
    p_rr = a_re * b_re;
    p_ii = a_im * b_im;
    p_ri = a_re * b_im;
    p_ir = a_im * b_re;
    s_re = p_rr - p_ii;
    s_im = p_ri + p_ir;
    re   = {1'b0, s_re[W-1:1]};
    im   = {1'b0, s_im[W-1:1]};
  end
endmodule

// Grant slice for one requester.
// The lane wins if it is valid and no valid lane lies earlier in the scan starting at rr_ptr.
module cmul_rr_lane #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int IDX     = 0
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [TAG_W-1:0]   rr_ptr,
  output logic               grant
);
  // Scan distance of lane idx from the pointer, wrapping mod NUM_REQ.
  function automatic int dist_of(input int idx, input int p);
    return (idx >= p) ? (idx - p) : (idx + NUM_REQ - p);
  endfunction

  logic blk;

  // A lane is blocked by any valid lane closer to the pointer.
  always_comb begin
    blk = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_valid[j] && (dist_of(j, int'(rr_ptr)) < dist_of(IDX, int'(rr_ptr))))
        blk = 1'b1;
    end
    grant = req_valid[IDX] & ~blk;
  end
endmodule

module cmul_share_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_a_re,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_a_im,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_b_re,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_b_im,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [TAG_W-1:0]                res_tag,
  output logic [DATA_WIDTH:0]             res_re,
  output logic [DATA_WIDTH:0]             res_im,
  output logic                            busy
);
  localparam int W      = DATA_WIDTH + 1;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W-1:0] a_re;
    logic [W-1:0] a_im;
    logic [W-1:0] b_re;
    logic [W-1:0] b_im;
  } cop_t;

  cop_t [NUM_REQ-1:0] ops;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   rr_ptr, gidx, s1_tag;
  cop_t               s1_op;
  logic [STAGES:1]    vld_pipe;
  logic               s1_valid, adv1, adv2, acc;
  logic [W-1:0]       m_re, m_im;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign ops[gi].a_re = req_a_re[gi*W +: W];
      assign ops[gi].a_im = req_a_im[gi*W +: W];
      assign ops[gi].b_re = req_b_re[gi*W +: W];
      assign ops[gi].b_im = req_b_im[gi*W +: W];
      cmul_rr_lane #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .IDX(gi)) u_lane (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant[gi])
      );
    end
  endgenerate

  assign s1_valid  = vld_pipe[1];
  assign res_valid = vld_pipe[2];
  assign adv2      = ~res_valid | res_ready;
  assign adv1      = ~s1_valid | adv2;
  // Reset masks the strobe so that a handshake presented during reset is never taken.
  assign req_ready = grant & {NUM_REQ{adv1 & ~rst}};
  assign acc       = |req_ready;
  assign busy      = s1_valid | res_valid;

  // Encode the one-hot grant into the requester tag.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = TAG_W'(i);
  end

  // Round-robin pointer moves past the accepted requester.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (acc)
      rr_ptr <= (gidx == TAG_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end

  // Stage 1 captures the granted operands whenever it can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      s1_op       <= '0;
      s1_tag      <= '0;
    end else if (adv1) begin
      vld_pipe[1] <= acc;
      if (acc) begin
        s1_op  <= ops[gidx];
        s1_tag <= gidx;
      end
    end
  end

  mul_complex #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .a_re (s1_op.a_re),
    .a_im (s1_op.a_im),
    .b_re (s1_op.b_re),
    .b_im (s1_op.b_im),
    .re   (m_re),
    .im   (m_im)
  );

  // Stage 2 registers the product and holds it steady while the result is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      res_tag     <= '0;
      res_re      <= '0;
      res_im      <= '0;
    end else if (adv2) begin
      vld_pipe[2] <= s1_valid;
      if (s1_valid) begin
        res_tag <= s1_tag;
        res_re  <= m_re;
        res_im  <= m_im;
      end
    end
  end
endmodule

// File: tb/tb_cmul_share_arbiter.sv
// Directed bench for cmul_share_arbiter.
// A transaction-queue model is checked against the DUT on every cycle.
// Literal checks pin the model's arithmetic and the grant order.
module tb_cmul_share_arbiter;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int TW = 2;
  localparam int W  = DW + 1;
  localparam longint MASK = (64'd1 << W) - 1;

  logic              clk, rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*W-1:0]    req_a_re, req_a_im, req_b_re, req_b_im;
  logic              res_valid, res_ready, busy;
  logic [TW-1:0]     res_tag;
  logic [W-1:0]      res_re, res_im;

  cmul_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a_re(req_a_re), .req_a_im(req_a_im), .req_b_re(req_b_re), .req_b_im(req_b_im),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_re(res_re), .res_im(res_im), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: items are kept in acceptance order.
  // The head is visible at the output once it is two edges old.
  typedef struct {
    int     tag;
    longint re;
    longint im;
    int     age;
  } txn_t;

  txn_t q[$];
  int   mp;
  bit   chk_en = 0;
  int   glog[$];
  int   rlog[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rdy_in_reset", 64'(req_ready), 64'd0);
      q.delete();
      mp = 0;
      chk_en = 1;
    end else if (chk_en) begin
      bit     exp_rv, d;
      int     g, n;
      logic [N-1:0] exp_rdy;
      exp_rv = (q.size() > 0) && (q[0].age >= 2);
      chk("res_valid", 64'(res_valid), 64'(exp_rv));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      chk("rr_ptr", 64'(dut.rr_ptr), 64'(mp));
      if (exp_rv) begin
        chk("res_tag", 64'(res_tag), 64'(q[0].tag));
        chk("res_re", 64'(res_re), 64'(q[0].re));
        chk("res_im", 64'(res_im), 64'(q[0].im));
      end
      n = q.size();
      d = exp_rv && res_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mp + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
      exp_rdy = (g >= 0 && (n - int'(d)) < 2) ? N'(1 << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      if (res_valid && res_ready) rlog.push_back(int'(res_tag));
      if (d) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (exp_rdy != 0) begin
        txn_t t;
        longint ar, ai, br, bi;
        ar = longint'(req_a_re[g*W +: W]);
        ai = longint'(req_a_im[g*W +: W]);
        br = longint'(req_b_re[g*W +: W]);
        bi = longint'(req_b_im[g*W +: W]);
        t.tag = g;
        t.re  = ((ar*br - ai*bi) & MASK) >> 1;
        t.im  = ((ar*bi + ai*br) & MASK) >> 1;
        t.age = 1;
        q.push_back(t);
        mp = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] ar, ai, br, bi);
    req_a_re[i*W +: W] = ar;
    req_a_im[i*W +: W] = ai;
    req_b_re[i*W +: W] = br;
    req_b_im[i*W +: W] = bi;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    glog.delete();
    rlog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    req_a_re = '0; req_a_im = '0; req_b_re = '0; req_b_im = '0;
    for (int i = 0; i < N; i++) set_ops(i, W'(i+1), W'(2*i+3), W'(5*i+7), W'(300*i+11));
    tick(); tick();
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_re", 64'(res_re), 64'd0);
    rst = 1'b0;

    // Single request from lane 1.
    set_ops(1, 17'd3, 17'd1, 17'd2, 17'd5);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("single_rdy", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("single_vld", 64'(res_valid), 64'd1);
    chk("single_tag", 64'(res_tag), 64'd1);
    chk("single_re", 64'(res_re), 64'd0);
    chk("single_im", 64'(res_im), 64'd8);
    tick();
    chk("single_busy", 64'(busy), 64'd0);

    // Round robin between lanes 0 and 2.
    do_reset();
    req_valid = 4'b0101;
    repeat (6) tick();
    req_valid = '0;
    chk("rr_cnt", 64'(glog.size()), 64'd6);
    chk("rr_g0", 64'(glog[0]), 64'd0);
    chk("rr_g1", 64'(glog[1]), 64'd2);
    chk("rr_g2", 64'(glog[2]), 64'd0);
    chk("rr_g3", 64'(glog[3]), 64'd2);
    repeat (3) tick();

    // Pointer wrap with all lanes valid.
    do_reset();
    req_valid = 4'b1111;
    repeat (5) tick();
    req_valid = '0;
    chk("wrap_cnt", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("wrap_g%0d", i), 64'(glog[i]), 64'(i % N));
    chk("wrap_ptr", 64'(dut.rr_ptr), 64'd1);
    repeat (3) tick();

    // Backpressure: result port stalled for five cycles.
    res_ready = 1'b0;
    do_reset();
    req_valid = 4'b1111;
    repeat (2) tick();
    begin
      logic [TW-1:0] ht;
      logic [W-1:0]  hr, hi;
      ht = res_tag; hr = res_re; hi = res_im;
      chk("bp_vld", 64'(res_valid), 64'd1);
      repeat (3) begin
        tick();
        chk("bp_tag_hold", 64'(res_tag), 64'(ht));
        chk("bp_re_hold", 64'(res_re), 64'(hr));
        chk("bp_im_hold", 64'(res_im), 64'(hi));
        chk("bp_no_rdy", 64'(req_ready), 64'd0);
      end
    end
    chk("bp_acc", 64'(glog.size()), 64'd2);
    res_ready = 1'b1;
    repeat (2) tick();
    req_valid = '0;
    repeat (3) tick();
    chk("bp_gcnt", 64'(glog.size()), 64'd4);
    chk("bp_rcnt", 64'(rlog.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_tag%0d", i), 64'(rlog[i]), 64'(i));

    // Reset while both stages are full.
    do_reset();
    res_ready = 1'b0;
    set_ops(3, 17'd100, 17'd7, 17'd9, 17'd1);
    req_valid = 4'b1000;
    repeat (2) tick();
    chk("mid_full", 64'(busy), 64'd1);
    chk("mid_acc", 64'(glog.size()), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    chk("mid_res_valid", 64'(res_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ptr", 64'(dut.rr_ptr), 64'd0);
    glog.delete();
    req_valid = 4'b1001;
    res_ready = 1'b1;
    @(negedge clk);
    chk("mid_first", 64'(req_ready), 64'b0001);
    repeat (2) tick();
    req_valid = '0;
    chk("mid_g1", 64'(glog[1]), 64'd3);
    repeat (3) tick();

    // Arithmetic check on lane 2.
    set_ops(2, 17'd10, 17'd4, 17'd6, 17'd2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    chk("arith_vld", 64'(res_valid), 64'd1);
    chk("arith_tag", 64'(res_tag), 64'd2);
    chk("arith_re", 64'(res_re), 64'd26);
    chk("arith_im", 64'(res_im), 64'd22);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
